id_ex_skid: RTL
===============

ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 Parameter XLEN, default 32, operand/PC width in bits.
REQ-002 Parameter NOPS, default 2, number of operand channels (1..4).
REQ-003 Parameter RAW, default 5, destination register address width.
REQ-004 Parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single register with combinational ready.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  discard all held and incoming instructions.
REQ-008 in_valid  input  1  decode offers an instruction.
REQ-009 in_ready  output  1  stage can accept this cycle.
REQ-010 in_op  input  7  major opcode; 0 = bubble.
REQ-011 in_f3  input  3  funct3 subtype.
REQ-012 in_alt  input  1  alternate-op flag (sub/sra).
REQ-013 in_opnd  input  NOPS*XLEN  packed operands, channel k at bits [k*XLEN +: XLEN].
REQ-014 in_wa  input  RAW  destination register address.
REQ-015 in_we  input  1  register write enable.
REQ-016 in_pc  input  XLEN  instruction PC.
REQ-017 in_off  input  XLEN  branch/jump offset.
REQ-018 in_br  input  1  instruction redirects fetch.
REQ-019 out_valid  output  1  execute-side instruction valid.
REQ-020 out_ready  input  1  execute consumes this cycle.
REQ-021 out_op, out_f3, out_alt, out_opnd, out_wa, out_we  output  same widths as inputs  registered instruction fields.
REQ-022 br_valid  output  1  one-cycle fetch redirect strobe.
REQ-023 br_target  output  XLEN  redirect address.

Function
REQ-024 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-025 SKID=1: states EMPTY, ONE, TWO; in_ready = (state != TWO), registered, no combinational path from out_ready.
REQ-026 EMPTY: in-transfer -> ONE. ONE: in only -> TWO; out only -> EMPTY; both -> ONE with new entry on outputs next cycle. TWO: out -> ONE with skid entry promoted to outputs.
REQ-027 SKID=0: single entry; in_ready = !out_valid || out_ready.
REQ-028 Ordering strictly FIFO; no entry duplicated or lost absent flush.
REQ-029 In-transfer with in_op == 0: accepted, not stored, state unchanged, no br_valid.
REQ-030 Outputs with out_valid low: all fields 0.
REQ-031 br_target = (in_pc + in_off) mod 2^XLEN with bit 0 forced 0, registered on the cycle of a non-bubble in-transfer with in_br = 1.
REQ-032 br_valid high exactly one cycle after that transfer, low otherwise; br_target holds last value when br_valid low.
REQ-033 flush: next cycle state EMPTY, out_valid 0, br_valid 0; any same-cycle in-transfer dropped; flush overrides out-transfer and input.
REQ-034 Latency: input to out_valid one cycle when stage empty.
REQ-035 Operand channels independent; no cross-channel arithmetic.

Reset
REQ-036 rst high at clock edge: state EMPTY, out_valid 0, all out_* fields 0, br_valid 0, br_target 0; in_ready 1 on next cycle.
REQ-037 rst mid-operation discards held entries identically to flush; rst priority over flush.

Verification
REQ-038 Reset then in_op=0x33, opnd={5,7}, wa=3, we=1, out_ready=1 -> next cycle out_valid=1, out_opnd={5,7}, out_wa=3.
REQ-039 out_ready=0, three back-to-back inputs A,B,C -> A on outputs, B in skid, in_ready=0, C stalled; out_ready=1 -> A,B,C emerged in order on consecutive cycles.
REQ-040 in_pc=0x100, in_off=0x11, in_br=1 -> br_valid one cycle, br_target=0x110; in_pc=0xFFFFFFFC, in_off=8 -> br_target=0x4.
REQ-041 State TWO, flush with simultaneous in_valid -> next cycle out_valid=0, in_ready=1, dropped instruction never appears.
REQ-042 in_op=0 with in_valid=1, in_br=1 -> out_valid stays 0, br_valid stays 0.
REQ-043 Sweep NOPS=1,4 and SKID=0 -> scenarios 038-041 pass with channel k data intact.

Source files
------------

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with an optional two-entry skid buffer and a registered
// branch-redirect strobe computed from the incoming instruction.
module id_ex_skid #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NOPS = 2,
   parameter int unsigned RAW  = 5,
   parameter int unsigned SKID = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_op,
   input  logic [2:0]           in_f3,
   input  logic                 in_alt,
   input  logic [NOPS*XLEN-1:0] in_opnd,
   input  logic [RAW-1:0]       in_wa,
   input  logic                 in_we,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [XLEN-1:0]      in_off,
   input  logic                 in_br,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [6:0]           out_op,
   output logic [2:0]           out_f3,
   output logic                 out_alt,
   output logic [NOPS*XLEN-1:0] out_opnd,
   output logic [RAW-1:0]       out_wa,
   output logic                 out_we,
   output logic                 br_valid,
   output logic [XLEN-1:0]      br_target
);

   localparam int unsigned OW = NOPS * XLEN;
   localparam int unsigned EW = 7 + 3 + 1 + OW + RAW + 1;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e          state_q, state_d;
   logic [EW-1:0]   main_q, main_d;
   logic [EW-1:0]   skid_q, skid_d;
   logic [EW-1:0]   in_ent;
   logic            push, pop;
   logic            br_valid_q;
   logic [XLEN-1:0] br_target_q, br_target_d;

   assign in_ent = {in_op, in_f3, in_alt, in_opnd, in_wa, in_we};

   // With SKID=0 the single entry may be refilled in the cycle it drains.
   assign in_ready  = (SKID != 0) ? (state_q != StTwo) : ((state_q == StEmpty) || out_ready);
   assign out_valid = (state_q != StEmpty);
   assign pop       = out_valid && out_ready;
   // Bubbles are consumed but never stored; flush drops any incoming instruction.
   assign push      = in_valid && in_ready && (in_op != 7'd0) && !flush;

   assign br_target_d = (in_pc + in_off) & {{(XLEN-1){1'b1}}, 1'b0};

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = StEmpty;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  state_d = StOne;
                  main_d  = in_ent;
               end
            end
            StOne: begin
               if (push && !pop) begin
                  state_d = StTwo;
                  skid_d  = in_ent;
               end else if (push && pop) begin
                  main_d = in_ent;
               end else if (pop) begin
                  state_d = StEmpty;
                  main_d  = '0;
               end
            end
            StTwo: begin
               if (pop) begin
                  state_d = StOne;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = StEmpty;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_valid_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         br_valid_q <= push && in_br;
         if (push && in_br) begin
            br_target_q <= br_target_d;
         end
      end
   end

   assign {out_op, out_f3, out_alt, out_opnd, out_wa, out_we} = main_q;
   assign br_valid  = br_valid_q;
   assign br_target = br_target_q;

endmodule
